// File: rtl/c157x_sd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : c157x_sd_arbiter
// Round-robin arbiter that multiplexes per-drive SD block requests onto the
// single host SD image port. The grant is held for the whole ack burst.
// Rev    : 1.0
// ============================================================================
module c157x_sd_arbiter #(
  parameter int NDRIVES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [32*NDRIVES-1:0] drv_lba,
  input  logic [6*NDRIVES-1:0]  drv_blk_cnt,
  input  logic [NDRIVES-1:0]    drv_rd,
  input  logic [NDRIVES-1:0]    drv_wr,
  output logic [NDRIVES-1:0]    drv_ack,
  input  logic [8*NDRIVES-1:0]  drv_buff_din,
  output logic [31:0]           sd_lba,
  output logic [5:0]            sd_blk_cnt,
  output logic                  sd_rd,
  output logic                  sd_wr,
  input  logic                  sd_ack,
  output logic [7:0]            sd_buff_din,
  output logic                  busy
);

  localparam int SEL_W = (NDRIVES > 1) ? $clog2(NDRIVES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [31:0]        lba_q, lba_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;

  logic               scan_hit;
  logic [SEL_W-1:0]   scan_idx;
  logic [31:0]        scan_lba;
  logic [5:0]         scan_cnt;
  logic               scan_rd;
  logic               scan_wr;

  // Scan from rr_ptr+NDRIVES down to rr_ptr+1 so the nearest requester after
  // the last-served drive is written last and wins.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    scan_lba = '0;
    scan_cnt = '0;
    scan_rd  = 1'b0;
    scan_wr  = 1'b0;
    for (int k = NDRIVES; k >= 1; k--) begin
      for (int i = 0; i < NDRIVES; i++) begin
        if ((drv_rd[i] || drv_wr[i]) && (i == (int'(rr_ptr_q) + k) % NDRIVES)) begin
          scan_hit = 1'b1;
          scan_idx = i[SEL_W-1:0];
          scan_lba = drv_lba[32*i +: 32];
          scan_cnt = drv_blk_cnt[6*i +: 6];
          scan_rd  = drv_rd[i];
          scan_wr  = drv_wr[i];
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    lba_d    = lba_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    case (state_q)
      ST_IDLE: begin
        // A stale ack (e.g. left over after reset) blocks any new grant.
        if (!sd_ack && scan_hit) begin
          sel_d   = scan_idx;
          lba_d   = scan_lba;
          cnt_d   = scan_cnt;
          wr_d    = scan_wr;
          rd_d    = scan_rd & ~scan_wr;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!sd_ack) begin
          rr_ptr_d = sel_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      lba_q    <= '0;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      lba_q    <= lba_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  // Ack and write data are routed combinationally so the ack edge reaches
  // the granted drive in the same cycle the host raises it.
  always_comb begin
    drv_ack     = '0;
    sd_buff_din = '0;
    for (int i = 0; i < NDRIVES; i++) begin
      if (state_q != ST_IDLE && sel_q == i[SEL_W-1:0]) begin
        drv_ack[i]  = sd_ack;
        sd_buff_din = drv_buff_din[8*i +: 8];
      end
    end
  end

  assign sd_lba     = lba_q;
  assign sd_blk_cnt = cnt_q;
  assign sd_rd      = rd_q;
  assign sd_wr      = wr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_c157x_sd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_c157x_sd_arbiter
// Directed bench for c157x_sd_arbiter (NDRIVES=2) with a host-command scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_c157x_sd_arbiter;

  localparam int N = 2;

  logic          clk          = 1'b0;
  logic          reset        = 1'b1;
  logic [63:0]   drv_lba      = '0;
  logic [11:0]   drv_blk_cnt  = '0;
  logic [1:0]    drv_rd       = '0;
  logic [1:0]    drv_wr       = '0;
  logic [1:0]    drv_ack;
  logic [15:0]   drv_buff_din = 16'hA53C;
  logic [31:0]   sd_lba;
  logic [5:0]    sd_blk_cnt;
  logic          sd_rd;
  logic          sd_wr;
  logic          sd_ack       = 1'b0;
  logic [7:0]    sd_buff_din;
  logic          busy;

  c157x_sd_arbiter #(.NDRIVES(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .drv_lba      (drv_lba),
    .drv_blk_cnt  (drv_blk_cnt),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_ack      (drv_ack),
    .drv_buff_din (drv_buff_din),
    .sd_lba       (sd_lba),
    .sd_blk_cnt   (sd_blk_cnt),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_din  (sd_buff_din),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  mask;
    logic [31:0] lba;
    logic [5:0]  cnt;
    logic        rd;
    logic        wr;
  } cmd_t;

  cmd_t       exp_q[$];
  cmd_t       mon_e;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] cur_mask = '0;
  logic [1:0] exp_ack;
  logic       prev_cmd = 1'b0;
  logic       mon_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] mask, input logic [31:0] lba,
                      input logic [5:0] cnt, input logic rd, input logic wr);
    cmd_t e;
    e.mask = mask;
    e.lba  = lba;
    e.cnt  = cnt;
    e.rd   = rd;
    e.wr   = wr;
    exp_q.push_back(e);
  endtask

  // Monitor: each new host command is checked against the scoreboard, and
  // drv_ack is checked every cycle against the currently granted drive.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if ((sd_rd || sd_wr) && !prev_cmd) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_cmd", 64'({sd_lba, sd_rd, sd_wr}), 64'd0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("host_cmd", 64'({sd_lba, sd_blk_cnt, sd_rd, sd_wr}),
                64'({mon_e.lba, mon_e.cnt, mon_e.rd, mon_e.wr}));
            cur_mask = mon_e.mask;
          end
        end
        exp_ack = (busy && sd_ack) ? cur_mask : 2'b00;
        chk("drv_ack", 64'(drv_ack), 64'(exp_ack));
        prev_cmd = sd_rd || sd_wr;
      end
    end
  end

  task automatic wait_cmd();
    int t;
    t = 0;
    while (!(sd_rd || sd_wr) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_wait", 64'(sd_rd || sd_wr), 64'd1);
  endtask

  // Host side of one transfer for drive drv, ack held ncyc cycles.
  task automatic serve(input bit drv, input int ncyc);
    wait_cmd();
    @(posedge clk);
    #1 sd_ack = 1'b1;
    @(negedge clk);
    chk("ack_same_cycle", 64'(drv_ack), 64'(drv ? 2'b10 : 2'b01));
    chk("buff_din", 64'(sd_buff_din), 64'(drv ? 8'hA5 : 8'h3C));
    @(posedge clk);
    #1 drv_rd[drv] = 1'b0;
    drv_wr[drv] = 1'b0;
    @(negedge clk);
    chk("cmd_cleared", 64'({sd_rd, sd_wr}), 64'd0);
    repeat (ncyc - 2) @(posedge clk);
    #1 sd_ack = 1'b0;
    @(negedge clk);
    chk("busy_before_fall", 64'(busy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_fall", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 64'({sd_rd, sd_wr, busy, drv_ack}), 64'd0);
    chk("reset_data", 64'({sd_lba, sd_blk_cnt, sd_buff_din}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    // Single read with 1-cycle request latency
    @(posedge clk);
    #1 drv_lba[31:0] = 32'h0000_0123;
    drv_blk_cnt[5:0] = 6'd30;
    drv_rd[0] = 1'b1;
    push(2'b01, 32'h123, 6'd30, 1'b1, 1'b0);
    @(negedge clk);
    chk("rd_not_yet", 64'(sd_rd), 64'd0);
    @(negedge clk);
    chk("rd_latency", 64'({sd_rd, busy}), 64'b11);
    serve(1'b0, 40);

    // Collision with rr_ptr=0: drive 1 first, then drive 0
    drv_lba = {32'h0000_2000, 32'h0000_1000};
    drv_blk_cnt = {6'd7, 6'd5};
    drv_rd = 2'b11;
    push(2'b10, 32'h2000, 6'd7, 1'b1, 1'b0);
    push(2'b01, 32'h1000, 6'd5, 1'b1, 1'b0);
    serve(1'b1, 4);
    serve(1'b0, 4);

    // Write wins over read; data routed from the granted drive
    drv_lba[63:32] = 32'h0BAD_F00D;
    drv_blk_cnt[11:6] = 6'd2;
    drv_rd[1] = 1'b1;
    drv_wr[1] = 1'b1;
    push(2'b10, 32'h0BAD_F00D, 6'd2, 1'b0, 1'b1);
    serve(1'b1, 3);

    // Reset during XFER with the host ack still high
    drv_lba[31:0] = 32'h55;
    drv_blk_cnt[5:0] = 6'd1;
    drv_rd[0] = 1'b1;
    push(2'b01, 32'h55, 6'd1, 1'b1, 1'b0);
    wait_cmd();
    @(posedge clk);
    #1 sd_ack = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("stale_reset_ctrl", 64'({sd_rd, sd_wr, busy, drv_ack}), 64'd0);
    chk("stale_reset_data", 64'({sd_lba, sd_blk_cnt, sd_buff_din}), 64'd0);
    push(2'b01, 32'h55, 6'd1, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("stale_no_grant", 64'({sd_rd, sd_wr, busy}), 64'd0);
    end
    @(posedge clk);
    #1 sd_ack = 1'b0;
    @(negedge clk);
    chk("stale_idle_gap", 64'({sd_rd, busy}), 64'd0);
    @(negedge clk);
    chk("stale_regrant", 64'({sd_rd, busy}), 64'b11);
    serve(1'b0, 3);

    // Request withdrawn before ack: host command stays up
    drv_lba[31:0] = 32'h77;
    drv_blk_cnt[5:0] = 6'd3;
    drv_rd[0] = 1'b1;
    push(2'b01, 32'h77, 6'd3, 1'b1, 1'b0);
    @(posedge clk);
    #1 drv_rd[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("withdrawn_hold", 64'({sd_rd, busy}), 64'b11);
    serve(1'b0, 5);

    // Fairness: 0, 1, 0 with drive 1 LBA changing after its grant
    drv_lba[31:0] = 32'h100;
    drv_blk_cnt[5:0] = 6'd9;
    drv_rd[0] = 1'b1;
    push(2'b01, 32'h100, 6'd9, 1'b1, 1'b0);
    push(2'b10, 32'h200, 6'd4, 1'b1, 1'b0);
    push(2'b01, 32'h300, 6'd9, 1'b1, 1'b0);
    @(posedge clk);
    #1 drv_lba[63:32] = 32'h200;
    drv_blk_cnt[11:6] = 6'd4;
    drv_rd[1] = 1'b1;
    serve(1'b0, 3);
    drv_lba[31:0] = 32'h300;
    drv_rd[0] = 1'b1;
    wait_cmd();
    @(posedge clk);
    #1 drv_lba[63:32] = 32'hDEAD;
    @(negedge clk);
    chk("lba_immune", 64'(sd_lba), 64'h200);
    serve(1'b1, 3);
    serve(1'b0, 3);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/c157x_sd_arbiter.md
Name: c157x_sd_arbiter

Overview:
- Multiplexes the SD block-request ports of several c157x drive instances onto the single host SD image port.
- Sits downstream of each drive's track loader (sd_lba/sd_blk_cnt/sd_rd/sd_wr) and upstream of the host SD interface.
- Runs entirely in the SD-side clock domain. Grants one drive at a time, round-robin, and holds the grant for the whole ack burst.
- Routes ack and write-buffer data back to the granted drive only.

Parameters:
- NDRIVES, 2, number of drive ports (legal 1..4)

Ports:
- clk  in  1  SD-side system clock (clk_sys domain)
- reset  in  1  synchronous, active-high
- drv_lba  in  32*NDRIVES  per-drive LBA, drive i at [32*i +: 32]
- drv_blk_cnt  in  6*NDRIVES  per-drive block count minus one, drive i at [6*i +: 6]
- drv_rd  in  NDRIVES  per-drive read request, level, held until its ack rises
- drv_wr  in  NDRIVES  per-drive write request, level, held until its ack rises
- drv_ack  out  NDRIVES  per-drive ack; only the granted bit may be 1
- drv_buff_din  in  8*NDRIVES  per-drive write data for the host
- sd_lba  out  32  LBA to host
- sd_blk_cnt  out  6  block count to host
- sd_rd  out  1  host read request
- sd_wr  out  1  host write request
- sd_ack  in  1  host ack, high for the whole transfer
- sd_buff_din  out  8  write data to host, taken from the granted drive
- busy  out  1  high in any state other than IDLE

sd_buff_addr, sd_buff_dout and sd_buff_wr are broadcast to all drives outside this block. Drives qualify them with their own drv_ack.

Behaviour:
- Reset (reset=1 at a clk edge) forces:
  - state=IDLE, rr_ptr=0, sel=0
  - sd_rd=0, sd_wr=0, sd_lba=0, sd_blk_cnt=0, busy=0
  - drv_ack=0, sd_buff_din=0
  - A reset mid-transfer abandons the grant immediately. Outputs drop the next cycle.
- States: IDLE, REQ, XFER.
- IDLE:
  - No grant while sd_ack=1. This covers a stale ack left over after reset.
  - Otherwise scan i = rr_ptr+1, rr_ptr+2, ... modulo NDRIVES, wrapping to and including rr_ptr itself.
  - The first drive with drv_rd|drv_wr wins.
  - On a win, register:
    - sel = i
    - sd_lba = drv_lba[i], sd_blk_cnt = drv_blk_cnt[i]
    - sd_wr = drv_wr[i]
    - sd_rd = drv_rd[i] & ~drv_wr[i] (write wins if both are set, so no dirty track is lost)
  - Go to REQ. sd_rd/sd_wr are high on the cycle after the request is first seen (1-cycle latency).
- REQ:
  - Hold sd_lba, sd_blk_cnt, sd_rd, sd_wr stable.
  - When sd_ack=1: clear sd_rd and sd_wr (registered), go to XFER.
  - If the granted drive drops its request before ack, the host command is not cancelled. REQ still waits for ack and routes it.
- XFER:
  - drv_ack[sel] follows sd_ack combinationally; all other drv_ack bits are 0.
  - When sd_ack=0: set rr_ptr=sel and go to IDLE. No new grant is made on that same edge.
- drv_ack[sel]=sd_ack also holds in REQ, so the rising edge of ack reaches the drive in the same cycle.
- sd_buff_din = drv_buff_din[sel] in REQ and XFER, 0 in IDLE.
- Fairness: a drive that has just been served has lowest priority next round. Back-to-back requests from one drive alternate with any other pending drive.
- New requests arriving during REQ/XFER are ignored until IDLE. The latched LBA is immune to later drv_lba changes.
- NDRIVES=1: the modulo scan degenerates to drive 0. Behaviour is otherwise identical.
- Minimum gap between two host commands: ack falling edge, then 1 cycle in IDLE, then request high on the following cycle.

Test Plan:
- Single read: drv_rd[0]=1, drv_lba[0]=0x0000_0123, drv_blk_cnt[0]=30 → next cycle sd_rd=1, sd_lba=0x123, sd_blk_cnt=30. Ack held 40 cycles → drv_ack=2'b01 throughout, sd_rd low the cycle after ack rises, busy falls the cycle after ack falls.
- Collision, NDRIVES=2, rr_ptr=0: drv_rd=2'b11 in the same cycle → drive 1 granted first. After its ack completes, drive 0 is granted with its own LBA. drv_ack bits never both 1.
- Write priority and data routing: drv_rd[1]=drv_wr[1]=1 → sd_wr=1, sd_rd=0. During ack, drv_buff_din[1]=0xA5 and drv_buff_din[0]=0x3C → sd_buff_din=0xA5.
- Stale ack: assert reset during XFER with sd_ack=1 → next cycle all outputs 0. Pending drv_rd[0] is not granted until sd_ack falls; it is then granted one cycle later.
- Request withdrawn: drv_rd[0] asserted then dropped before ack → sd_rd stays 1 until ack. Ack is routed to drv_ack[0]; arbiter returns to IDLE on ack fall.
- Fairness: drive 0 re-requests continuously while drive 1 requests once → grant sequence 0,1,0. Drive 1's LBA change after grant does not alter sd_lba.
